// File: rtl/scan_index_sequencer.sv
// scan_index_sequencer
// Steps a 4-bit row index through the unmasked rows in ascending order.
// Each row is held for DWELL_CYCLES cycles. The index drives a 4-to-16
// one-hot decoder, and valid gates that decoder's output downstream.
//
// Optional build macro SCAN_WRAP_EN: when it is defined, a finished frame
// restarts at the lowest unmasked row without leaving DWELL. In that case
// frame_done pulses on the restart cycle.
//
// Handshake: start and stop are level-sampled, single-cycle requests. There
// is no ready signal. A start is accepted only in IDLE, only with stop low,
// and only when at least one row is unmasked. stop is honoured only in DWELL.
module scan_index_sequencer #(
  parameter int DWELL_CYCLES = 4,
  parameter int N_ROWS       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] mask,
  output logic [3:0]  binary,
  output logic        valid,
  output logic        busy,
  output logic        frame_done,
  output logic [4:0]  row_cnt
);

  localparam logic [15:0] ALL_MASKED = 16'((33'd1 << N_ROWS) - 33'd1);
  localparam logic [7:0]  LAST_CNT   = 8'(DWELL_CYCLES - 1);

  typedef enum logic {IDLE, DWELL} state_t;

  // State is observable by hierarchical reference for checkers.
  state_t      state, state_n;
  logic [15:0] mask_q, mask_q_n;
  logic [7:0]  dwell_cnt, dwell_cnt_n;
  logic [3:0]  binary_n;
  logic        valid_n, busy_n, frame_done_n;
  logic [4:0]  row_cnt_n;

  // Search result is {found, index} for the lowest row at or above lo.
  function automatic logic [4:0] first_clear_from(input logic [15:0] m,
                                                  input logic [4:0]  lo);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (!m[i] && (5'(i) >= lo)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  logic [4:0] first_in;    // lowest unmasked row of the incoming mask
  logic [4:0] first_q;     // lowest unmasked row of the captured mask
  logic [4:0] next_row;    // next unmasked row above the current one

  // Row searches for the start of a frame and for advancing within one.
  always_comb begin
    first_in = first_clear_from(mask, 5'd0);
    first_q  = first_clear_from(mask_q, 5'd0);
    next_row = first_clear_from(mask_q, {1'b0, binary} + 5'd1);
  end

  // Next-state and next-output logic. Every output is registered.
  always_comb begin
    state_n      = state;
    mask_q_n     = mask_q;
    dwell_cnt_n  = dwell_cnt;
    binary_n     = binary;
    valid_n      = valid;
    busy_n       = busy;
    frame_done_n = 1'b0;
    row_cnt_n    = row_cnt;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        if (start && !stop && (mask != ALL_MASKED)) begin
          mask_q_n    = mask;
          binary_n    = first_in[3:0];
          valid_n     = 1'b1;
          busy_n      = 1'b1;
          row_cnt_n   = 5'd1;
          dwell_cnt_n = 8'd0;
          state_n     = DWELL;
        end
      end
      DWELL: begin
        if (stop) begin
          valid_n = 1'b0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (dwell_cnt == LAST_CNT) begin
          dwell_cnt_n = 8'd0;
          if (next_row[4]) begin
            binary_n  = next_row[3:0];
            row_cnt_n = row_cnt + 5'd1;
          end else begin
            frame_done_n = 1'b1;
`ifdef SCAN_WRAP_EN
            binary_n  = first_q[3:0];
            row_cnt_n = 5'd1;
`else
            valid_n = 1'b0;
            busy_n  = 1'b0;
            state_n = IDLE;
`endif
          end
        end else begin
          dwell_cnt_n = dwell_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mask_q     <= 16'd0;
      dwell_cnt  <= 8'd0;
      binary     <= 4'd0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      row_cnt    <= 5'd0;
    end else begin
      state      <= state_n;
      mask_q     <= mask_q_n;
      dwell_cnt  <= dwell_cnt_n;
      binary     <= binary_n;
      valid      <= valid_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      row_cnt    <= row_cnt_n;
    end
  end

  // The first-row search of the captured mask is only needed for wrapping.
  logic unused_first_q;
  assign unused_first_q = ^first_q;

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Testbench for scan_index_sequencer. A schedule-based reference model
// expands each frame into a queue of per-cycle rows. A compare process
// checks every cycle against that model. Directed cases pin the model to
// literal values.
module tb_scan_index_sequencer;

  localparam int DWELL = 2;

  logic        clk, rst, start, stop;
  logic [15:0] mask;
  logic [3:0]  binary;
  logic        valid, busy, frame_done;
  logic [4:0]  row_cnt;

  int n_vec = 0;
  int n_err = 0;

  scan_index_sequencer #(.DWELL_CYCLES(DWELL), .N_ROWS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mask(mask),
    .binary(binary), .valid(valid), .busy(busy),
    .frame_done(frame_done), .row_cnt(row_cnt)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Each entry is {first_cycle_of_row, row}.
  logic [4:0]  sched[$];
  logic [15:0] m_mask;
  logic [3:0]  e_bin;
  logic        e_valid, e_busy, e_done;
  logic [4:0]  e_cnt;

  task automatic build(input logic [15:0] m);
    sched.delete();
    for (int r = 0; r < 16; r++)
      if (!m[r])
        for (int d = 0; d < DWELL; d++) sched.push_back({(d == 0), 4'(r)});
  endtask

  task automatic load_next();
    logic [4:0] e;
    e = sched.pop_front();
    e_bin = e[3:0];
    if (e[4]) e_cnt = e_cnt + 5'd1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_bin = 4'd0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_cnt = 5'd0;
      sched.delete();
    end else begin
      e_done = 1'b0;
      if (e_busy) begin
        if (stop) begin
          e_valid = 1'b0; e_busy = 1'b0; sched.delete();
        end else if (sched.size() > 0) begin
          load_next();
        end else begin
          e_done = 1'b1;
`ifdef SCAN_WRAP_EN
          build(m_mask); e_cnt = 5'd0; load_next();
`else
          e_valid = 1'b0; e_busy = 1'b0;
`endif
        end
      end else if (start && !stop && mask != 16'hFFFF) begin
        m_mask = mask; build(mask); e_cnt = 5'd0; load_next();
        e_valid = 1'b1; e_busy = 1'b1;
      end
    end
  end

  // Scoreboard: every cycle outside reset, outputs must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("binary", 32'(binary), 32'(e_bin));
      chk("valid", 32'(valid), 32'(e_valid));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("row_cnt", 32'(row_cnt), 32'(e_cnt));
    end
  end

  // Driver tasks.
  task automatic pulse_start(input logic [15:0] m);
    start = 1'b1; mask = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus.
  initial begin
    logic [15:0] rows[$];
    logic [15:0] exp_hot [4];
    int vcnt, dcnt;
    bit hit, did;

    rst = 1'b1; start = 1'b0; stop = 1'b0; mask = 16'd0;
    idle_cycles(2);
    #1 rst = 1'b0;
    chk("reset_binary", 32'(binary), 32'd0);
    chk("reset_row_cnt", 32'(row_cnt), 32'd0);
    idle_cycles(1);

    // Asynchronous reset while row 5 is being shown.
    pulse_start(16'h0000);
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (valid && binary == 4'd5) hit = 1; else @(negedge clk);
    end
    chk("reach_row5", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_binary", 32'(binary), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    idle_cycles(2);
    chk("post_arst_done", 32'(frame_done), 32'd0);

`ifndef SCAN_WRAP_EN
    // Full frame with no rows masked.
    pulse_start(16'h0000);
    vcnt = 0;
    for (int c = 0; c < 100 && !frame_done; c++) begin
      if (valid) vcnt++;
      @(negedge clk);
    end
    chk("full_done", 32'(frame_done), 32'd1);
    chk("full_done_valid", 32'(valid), 32'd0);
    chk("full_valid_cycles", 32'(vcnt), 32'd32);
    chk("full_row_cnt", 32'(row_cnt), 32'd16);
    idle_cycles(2);

    // Sparse mask decoded to one-hot.
    exp_hot[0] = 16'h0002; exp_hot[1] = 16'h0080;
    exp_hot[2] = 16'h1000; exp_hot[3] = 16'h8000;
    pulse_start(~16'b1001_0000_1000_0010);
    rows.delete();
    for (int c = 0; c < 40 && !frame_done; c++) begin
      if (valid && (rows.size() == 0 || rows[rows.size()-1] != (16'h1 << binary)))
        rows.push_back(16'h1 << binary);
      @(negedge clk);
    end
    chk("sparse_rows", 32'(rows.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("sparse_onehot", (i < rows.size()) ? 32'(rows[i]) : 32'hDEAD, 32'(exp_hot[i]));
    chk("sparse_done", 32'(frame_done), 32'd1);
    chk("sparse_row_cnt", 32'(row_cnt), 32'd4);
    idle_cycles(2);

    // Fully masked start is ignored.
    pulse_start(16'hFFFF);
    dcnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (valid || busy || frame_done) dcnt++;
      @(negedge clk);
    end
    chk("allmask_quiet", 32'(dcnt), 32'd0);
    chk("allmask_row_cnt", 32'(row_cnt), 32'd4);
`endif

    // Stop at row 7, with an ignored start and a mask change along the way.
    pulse_start(16'h0000);
    did = 0; hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      if (valid && binary == 4'd3 && !did) begin
        start = 1'b1; mask = 16'hFFF0; did = 1;
      end else start = 1'b0;
      if (valid && binary == 4'd7) begin
        hit = 1; stop = 1'b1;
      end
      @(negedge clk);
    end
    stop = 1'b0; start = 1'b0;
    chk("stop_reached", 32'(hit), 32'd1);
    chk("stop_valid", 32'(valid), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_binary", 32'(binary), 32'd7);
    chk("stop_row_cnt", 32'(row_cnt), 32'd8);
    chk("stop_no_done", 32'(frame_done), 32'd0);
    idle_cycles(2);

`ifdef SCAN_WRAP_EN
    // Wrapping over rows 0 and 2.
    pulse_start(~16'h0005);
    vcnt = 0; dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (valid) vcnt++;
      if (frame_done) dcnt++;
      @(negedge clk);
    end
    chk("wrap_valid_cycles", 32'(vcnt), 32'd12);
    chk("wrap_done_pulses", 32'(dcnt), 32'd2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("wrap_stop_valid", 32'(valid), 32'd0);
    idle_cycles(1);
`endif

    // Random stimulus against the model.
    for (int it = 0; it < 1500; it++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0: mask = 16'h0000;
        1: mask = 16'hFFFF;
        2: mask = 16'($urandom);
        default: mask = ~(16'h1 << $urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 199) == 0) begin
        #3 rst = 1'b1;
        #1 rst = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0;
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
